mul_pipe: RTL and testbench

Parametrised, pipelined RV32M/RV64M multiplier with a valid/ready handshake on both sides. Supports all four multiply ops (MUL, MULH, MULHSU, MULHU) through one shared (WIDTH+1)x(WIDTH+1) signed product. Returns the architecturally selected WIDTH-bit result with a caller tag. Sits between the coprocessor decode/issue stage and the register writeback arbiter. Accepts one op per cycle, supports backpressure and pipeline flush.

---
 rtl/mul_pipe.sv | 117 +++++++++++
 tb/tb_mul_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe.sv
// Pipelined RV32M/RV64M multiplier: MUL/MULH/MULHSU/MULHU.
// Valid/ready on both sides, flush kills all in-flight ops.
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mul_type,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;

  logic              s_a;
  logic              s_b;
  logic              lo;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] move;
  logic [WIDTH-1:0]  res_q;
  logic [TAG_W-1:0]  tag_q;

  // Only the low 2*WIDTH bits of the (WIDTH+1)-bit signed
  // product are ever selected, so extend straight to 2*WIDTH.
  assign s_a   = (mul_type != 2'b11);
  assign s_b   = !mul_type[1];
  assign lo    = (mul_type == 2'b00);
  assign a_ext = {{WIDTH{a[WIDTH-1] & s_a}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1] & s_b}}, b};
  assign prod  = a_ext * b_ext;

  // A stage can load unless it and every stage after it
  // are full while the consumer stalls.
  for (genvar g = 0; g < STAGES; g++) begin : g_move
    assign move[g] = out_ready || !(&valid[STAGES-1:g]);
  end

  assign in_ready  = move[0] && !flush;
  assign out_valid = valid[STAGES-1];
  assign busy      = |valid;
  assign out_res   = res_q;
  assign out_tag   = tag_q;

  // Valid bits: shift forward, cleared by reset or flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (move[0]) valid[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (move[i]) valid[i] <= valid[i-1];
      end
    end
  end

  if (STAGES == 1) begin : g_one
    // Single stage: select the word at capture time.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        res_q <= '0;
        tag_q <= '0;
      end else if (in_valid && in_ready) begin
        res_q <= lo ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
        tag_q <= in_tag;
      end
    end
  end else begin : g_multi
    logic [PW-1:0]    p_q  [STAGES-1];
    logic [TAG_W-1:0] t_q  [STAGES-1];
    logic [STAGES-2:0] lo_q;

    // Product stages: no reset, retimable by synthesis.
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
        p_q[0]  <= prod;
        t_q[0]  <= in_tag;
        lo_q[0] <= lo;
      end
      for (int i = 1; i < STAGES - 1; i++) begin
        if (move[i] && valid[i-1]) begin
          p_q[i]  <= p_q[i-1];
          t_q[i]  <= t_q[i-1];
          lo_q[i] <= lo_q[i-1];
        end
      end
    end

    // Output stage holds only the selected word and tag.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        res_q <= '0;
        tag_q <= '0;
      end else if (move[STAGES-1] && valid[STAGES-2]) begin
        res_q <= lo_q[STAGES-2] ? p_q[STAGES-2][WIDTH-1:0]
                                : p_q[STAGES-2][PW-1:WIDTH];
        tag_q <= t_q[STAGES-2];
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: ops, stall, flush,
// async reset and a STAGES/WIDTH=64 latency sweep.
module tb_mul_pipe;

  localparam int S = 3;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  mul_type;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;
  logic        busy;

  logic        w_valid;
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [1:0]  w_type;
  logic [4:0]  w_tag;
  logic        w_flush;
  logic        w_out_ready;
  logic        w1_in_ready, w5_in_ready;
  logic        w1_out_valid, w5_out_valid;
  logic [63:0] w1_out_res, w5_out_res;
  logic [4:0]  w1_out_tag, w5_out_tag;
  logic        w1_busy, w5_busy;

  int checks = 0;
  int failures = 0;
  int popped = 0;
  exp_t q[$];

  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [1:0]  vt [4];
  logic [31:0] vexp [4];

  always #5 clk = ~clk;

  mul_pipe #(.WIDTH(32), .STAGES(S), .TAG_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_type(mul_type), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .busy(busy)
  );

  mul_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5)) dut1 (
    .clk(clk), .resetn(resetn),
    .in_valid(w_valid), .in_ready(w1_in_ready),
    .a(w_a), .b(w_b), .mul_type(w_type), .in_tag(w_tag),
    .flush(w_flush),
    .out_valid(w1_out_valid), .out_ready(w_out_ready),
    .out_res(w1_out_res), .out_tag(w1_out_tag), .busy(w1_busy)
  );

  mul_pipe #(.WIDTH(64), .STAGES(5), .TAG_W(5)) dut5 (
    .clk(clk), .resetn(resetn),
    .in_valid(w_valid), .in_ready(w5_in_ready),
    .a(w_a), .b(w_b), .mul_type(w_type), .in_tag(w_tag),
    .flush(w_flush),
    .out_valid(w5_out_valid), .out_ready(w_out_ready),
    .out_res(w5_out_res), .out_tag(w5_out_tag), .busy(w5_busy)
  );

  // Golden: 64-bit product of the architecturally extended operands.
  function automatic logic [31:0] model(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [1:0]  t);
    logic [63:0] xe, ye, p;
    xe = (t == 2'b11) ? {32'b0, x} : {{32{x[31]}}, x};
    ye = (t[1])       ? {32'b0, y} : {{32{y[31]}}, y};
    p  = xe * ye;
    return (t == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshakes, then land at posedge+1.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (resetn && out_valid && out_ready && !flush) begin
      popped++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_extra observed_tag=%h expected=none", out_tag);
      end else begin
        e = q.pop_front();
        chk("sb_res", out_res, e.res);
        chk("sb_tag", out_tag, e.tag);
      end
    end
    if (resetn && in_valid && in_ready) begin
      e.res = model(a, b, mul_type);
      e.tag = in_tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Back-to-back burst with exact-latency checks.
  task automatic burst(input string nm, input int n);
    for (int i = 0; i < n + S; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        a        = va[i];
        b        = vb[i];
        mul_type = vt[i];
        in_tag   = 5'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < n) chk({nm, "_in_ready"}, in_ready, 1);
      chk({nm, "_out_valid"}, out_valid, (i >= S));
      if (i >= S) begin
        chk({nm, "_res"}, out_res, vexp[i-S]);
        chk({nm, "_tag"}, out_tag, 5'(i - S + 1));
      end
      cycle();
    end
  endtask

  task automatic drain(input string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && (q.size() != 0 || busy); k++) cycle();
    chk({nm, "_empty"}, q.size(), 0);
  endtask

  task automatic rnd_op(input logic [4:0] t);
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    mul_type = 2'($urandom_range(0, 3));
    in_tag   = t;
  endtask

  initial begin
    int sent, acc, lat, lat1, lat5;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;
    logic [63:0] r1, r5;

    resetn = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    mul_type = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    w_valid = 1'b0; w_a = '0; w_b = '0; w_type = '0;
    w_tag = '0; w_flush = 1'b0; w_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    cycle();

    // All four types on all-ones operands
    va   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vb   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt   = '{2'b00, 2'b01, 2'b10, 2'b11};
    vexp = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    burst("ones", 4);

    // Sign corners
    va   = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h0};
    vb   = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0};
    vt   = '{2'b01, 2'b10, 2'b00, 2'b00};
    vexp = '{32'h40000000, 32'h80000000, 32'h00000001, 32'h0};
    burst("corner", 3);
    drain("corner");

    // 20 streamed ops, 5-cycle consumer stall mid-stream
    popped   = 0;
    sent     = 0;
    hold_res = '0;
    hold_tag = '0;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      out_ready = !(c >= 8 && c < 13);
      rnd_op(5'(sent));
      #1;
      if (c == 8) begin
        hold_res = out_res;
        hold_tag = out_tag;
        chk("stall_in_ready", in_ready, 0);
      end
      if (c > 8 && c < 13) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_res_hold", out_res, hold_res);
        chk("stall_tag_hold", out_tag, hold_tag);
      end
      if (in_ready) sent++;
      cycle();
    end
    chk("stream_sent", sent, 20);
    drain("stream");
    chk("stream_popped", popped, 20);

    // Capacity: exactly S accepts with the consumer stalled
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      rnd_op(5'(20 + acc));
      #1;
      if (in_ready) acc++;
      cycle();
    end
    #1;
    chk("cap_accepts", acc, S);
    chk("cap_in_ready", in_ready, 0);
    chk("cap_busy", busy, 1);
    drain("cap");

    // Flush with three ops in flight
    for (int c = 0; c < 3; c++) begin
      rnd_op(5'(c + 8));
      cycle();
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("flush_busy_before", busy, 1);
    chk("flush_in_ready", in_ready, 0);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    in_valid = 1'b1; a = 32'd3; b = 32'd5;
    mul_type = 2'b00; in_tag = 5'h1A;
    #1;
    chk("post_flush_in_ready", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      if (out_valid) begin
        lat = k;
        chk("post_flush_res", out_res, 32'd15);
        chk("post_flush_tag", out_tag, 5'h1A);
      end
      cycle();
    end
    chk("post_flush_latency", lat, S);

    // Asynchronous reset with a full pipeline
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rnd_op(5'(c + 4));
      cycle();
    end
    in_valid = 1'b0;
    chk("prereset_busy", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_res", out_res, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("arst_no_stale", out_valid, 0);
    end

    // WIDTH=64 sweep: MULHU(all-ones, 2) on STAGES=1 and 5
    w_valid = 1'b1;
    w_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    w_b     = 64'd2;
    w_type  = 2'b11;
    w_tag   = 5'd7;
    #1;
    chk("w1_in_ready", w1_in_ready, 1);
    chk("w5_in_ready", w5_in_ready, 1);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    lat1 = 0; lat5 = 0; r1 = '0; r5 = '0;
    for (int k = 1; k <= 10; k++) begin
      if (w1_out_valid && lat1 == 0) begin
        lat1 = k;
        r1   = w1_out_res;
        chk("w1_tag", w1_out_tag, 7);
      end
      if (w5_out_valid && lat5 == 0) begin
        lat5 = k;
        r5   = w5_out_res;
        chk("w5_tag", w5_out_tag, 7);
      end
      @(posedge clk);
      #1;
    end
    chk("w1_latency", lat1, 1);
    chk("w1_res", r1, 64'd1);
    chk("w5_latency", lat5, 5);
    chk("w5_res", r5, 64'd1);
    chk("w1_idle", w1_busy, 0);
    chk("w5_idle", w5_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
